// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / product accumulator datapath.
// Width defaults are reused by the multiplier wrapper.
package mult_pkg;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums a programmed number of unsigned multiplier products into a wide register
// and returns the sum with a sticky carry-out flag over a valid/ready handshake.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PW = PROD_W,
  parameter int AW = ACC_W,
  parameter int LW = LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic          busy
);

  acc_state_t    r_state;
  logic [AW-1:0] r_acc;
  logic [LW-1:0] r_count;
  logic          r_ovf;
  logic          r_inReady;
  logic          r_outValid;
  logic          r_busy;

  // One extra bit captures the carry out of the accumulator's top bit.
  logic [AW:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + (AW+1)'(in_prod);

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  assign busy      = r_busy;

  // Handshake outputs are registered alongside the state so nothing downstream
  // sees a combinational path from in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_count   <= len;
              r_state   <= ACC;
              r_inReady <= 1'b1;
            end else begin
              r_state    <= DONE;
              r_outValid <= 1'b1;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            r_acc   <= w_sum[AW-1:0];
            r_ovf   <= r_ovf | w_sum[AW];
            r_count <= r_count - LW'(1);
            if (r_count == LW'(1)) begin
              r_state    <= DONE;
              r_inReady  <= 1'b0;
              r_outValid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b0;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives identical traffic into a 16-bit and a 10-bit accumulator and compares
// both against sums computed directly from the accepted products.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_prod;
  logic       out_ready;

  logic        inReady16, outValid16, outOvf16, busy16;
  logic [15:0] outSum16;
  logic        inReady10, outValid10, outOvf10, busy10;
  logic [9:0]  outSum10;

  int nVectors     = 0;
  int nMiscompares = 0;

  int prodQ[$];

  always #5 clk = ~clk;

  product_accumulator #(.PW(8), .AW(16), .LW(4)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(inReady16), .in_prod(in_prod),
    .out_valid(outValid16), .out_ready(out_ready),
    .out_sum(outSum16), .out_ovf(outOvf16), .busy(busy16)
  );

  product_accumulator #(.PW(8), .AW(10), .LW(4)) dut10 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(inReady10), .in_prod(in_prod),
    .out_valid(outValid10), .out_ready(out_ready),
    .out_sum(outSum10), .out_ovf(outOvf10), .busy(busy10)
  );

  // Guard against a DUT that never finishes a job.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic ir, input logic ov, input logic bz);
    checkOutput({tag, "_in_ready16"},  32'(inReady16),  32'(ir));
    checkOutput({tag, "_in_ready10"},  32'(inReady10),  32'(ir));
    checkOutput({tag, "_out_valid16"}, 32'(outValid16), 32'(ov));
    checkOutput({tag, "_out_valid10"}, 32'(outValid10), 32'(ov));
    checkOutput({tag, "_busy16"},      32'(busy16),     32'(bz));
    checkOutput({tag, "_busy10"},      32'(busy10),     32'(bz));
  endtask

  task automatic checkResult(input string tag, input int total);
    checkOutput({tag, "_sum16"}, 32'(outSum16), 32'(total % 65536));
    checkOutput({tag, "_ovf16"}, 32'(outOvf16), 32'(total >= 65536));
    checkOutput({tag, "_sum10"}, 32'(outSum10), 32'(total % 1024));
    checkOutput({tag, "_ovf10"}, 32'(outOvf10), 32'(total >= 1024));
  endtask

  // Runs one complete job using the products in prodQ. Inputs change and
  // outputs are sampled on the falling edge.
  task automatic applyStimulus(input string tag, input int gap, input int hold);
    int total = 0;
    foreach (prodQ[i]) total += prodQ[i];
    checkFlags({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    len   = 4'(prodQ.size());
    @(negedge clk);
    start = 1'b0;
    len   = 4'($urandom_range(0, 15));
    for (int i = 0; i < prodQ.size(); i++) begin
      checkFlags({tag, "_acc"}, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b1;
      in_prod  = 8'(prodQ[i]);
      @(negedge clk);
      in_valid = 1'b0;
      in_prod  = 8'($urandom_range(0, 255));
      if (i != prodQ.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          checkFlags({tag, "_gap"}, 1'b1, 1'b0, 1'b1);
          @(negedge clk);
        end
      end
    end
    checkFlags({tag, "_done"}, 1'b0, 1'b1, 1'b1);
    checkResult(tag, total);
    for (int h = 0; h < hold; h++) begin
      start    = 1'b1;
      len      = 4'($urandom_range(1, 15));
      in_valid = 1'b1;
      @(negedge clk);
      checkFlags({tag, "_hold"}, 1'b0, 1'b1, 1'b1);
      checkResult({tag, "_hold"}, total);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkFlags({tag, "_release"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    in_prod   = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    checkResult("reset", 0);

    prodQ = '{15, 100, 225};
    applyStimulus("basic", 0, 0);

    prodQ = '{1, 2, 3, 4};
    applyStimulus("gaps", 2, 0);

    prodQ = '{50, 60};
    applyStimulus("backpressure", 0, 5);

    prodQ = '{225, 225, 225, 225, 225};
    applyStimulus("overflow", 0, 1);

    prodQ = '{1, 1};
    applyStimulus("after_ovf", 0, 0);

    prodQ = {};
    applyStimulus("zero_len", 0, 2);

    // Abort a job partway through with reset.
    start = 1'b1;
    len   = 4'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_prod  = 8'd200;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkFlags("midreset", 1'b0, 1'b0, 1'b0);
    checkResult("midreset", 0);

    prodQ = '{7};
    applyStimulus("fresh", 0, 0);

    for (int j = 0; j < 40; j++) begin
      int n = $urandom_range(0, 15);
      prodQ = {};
      for (int k = 0; k < n; k++) prodQ.push_back($urandom_range(0, 225));
      applyStimulus("random", $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
